// File: rtl/cpu_pkg.sv
// Types shared by the pipeline memory ports and the unified SRAM arbiter.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

    typedef struct packed {
        logic [3:0]      wen;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_guard_cnt.sv
// Saturating run-length counter: bounds how long one requester can starve another.
module rr_guard_cnt #(
    parameter int W   = 4,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = MAX[W-1:0];

    // Clear has priority; counting stops once the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/unified_sram_arbiter.sv
// Shares one single-port SRAM between fetch and data ports; data has priority,
// with a run-length guard so fetch always makes progress.
module unified_sram_arbiter
    import cpu_pkg::*;
#(
    parameter int XLEN         = cpu_pkg::XLEN,
    parameter int AW           = 12,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [3:0]      i_wen,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic [3:0]      d_wen,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            sram_en,
    output logic [3:0]      sram_wen,
    output logic [AW-1:0]   sram_addr,
    output logic [XLEN-1:0] sram_wdata,
    input  logic [XLEN-1:0] sram_rdata
);

    logic          any_gnt;
    logic          at_max;
    logic [3:0]    run_cnt;
    mem_req_t      i_bus;
    mem_req_t      d_bus;
    mem_req_t      win;
    logic [AW-1:0] last_addr;
    logic          rd_pend;
    owner_t        rd_owner;
    logic          unused_addr_bits;

    assign i_bus = '{wen: i_wen, addr: i_addr, wdata: i_wdata};
    assign d_bus = '{wen: d_wen, addr: d_addr, wdata: d_wdata};

    // Grants are held off while reset is asserted so stale requests are ignored.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            if (d_req && !(i_req && at_max)) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    assign any_gnt = i_gnt | d_gnt;

    rr_guard_cnt #(
        .W   (4),
        .MAX (MAX_DATA_RUN)
    ) u_guard (
        .clk    (clk),
        .rst_n  (reset),
        .inc    (d_gnt & i_req),
        .clr    (i_gnt | ~i_req),
        .cnt    (run_cnt),
        .at_max (at_max)
    );

    always_comb begin
        win = '0;
        if (d_gnt) begin
            win = d_bus;
        end else if (i_gnt) begin
            win = i_bus;
        end
    end

    assign sram_en    = any_gnt;
    assign sram_wen   = win.wen;
    assign sram_wdata = win.wdata;
    assign sram_addr  = any_gnt ? win.addr[AW+1:2] : last_addr;

    // The owner tag only changes on a read grant; rd_pend alone qualifies it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_addr <= '0;
            rd_pend   <= 1'b0;
            rd_owner  <= OWNER_FETCH;
        end else begin
            if (any_gnt) begin
                last_addr <= win.addr[AW+1:2];
            end
            rd_pend <= any_gnt && (win.wen == 4'b0000);
            if (any_gnt && (win.wen == 4'b0000)) begin
                rd_owner <= d_gnt ? OWNER_DATA : OWNER_FETCH;
            end
        end
    end

    assign i_rvalid = rd_pend && (rd_owner == OWNER_FETCH);
    assign d_rvalid = rd_pend && (rd_owner == OWNER_DATA);
    assign i_rdata  = i_rvalid ? sram_rdata : '0;
    assign d_rdata  = d_rvalid ? sram_rdata : '0;

    assign unused_addr_bits = ^{win.addr[1:0], win.addr[cpu_pkg::XLEN-1:AW+2]};

endmodule
